// File: rtl/axi_pkg.sv
// AXI4 constants and helpers shared by the RAM filler and its burst calculator.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  // No AXI burst may cross a 4 KB address boundary.
  localparam int unsigned AXI_4K_BYTES = 4096;

  // AxSIZE encoding for a bus of data_width bits (bytes per beat = 2**size).
  function automatic logic [2:0] axi_size_from_width(input int unsigned data_width);
    logic [2:0] size;
    size = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((32'd8 << i) == data_width) size = 3'(i);
    end
    return size;
  endfunction

endpackage

// File: rtl/axi_burst_calc.sv
// Picks the beat count of the next INCR burst: min(remaining, MAX_BURST, beats to 4 KB edge).
// Latency: purely combinational.
// Backpressure: none; the caller holds the inputs stable while the result is consumed.
// Ports: addr_off  - low 12 bits of the burst start byte address
//        remaining - beats still to be written for the request
//        beats     - beat count of the next burst (0 only when remaining is 0)
module axi_burst_calc
  import axi_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16
) (
  input  logic [11:0] addr_off,
  input  logic [15:0] remaining,
  output logic [8:0]  beats
);

  localparam int unsigned SIZE_LOG = 32'(axi_size_from_width(DATA_W));
  localparam int unsigned WORDS_4K = AXI_4K_BYTES >> SIZE_LOG;

  logic [11:0] word_off;
  logic [16:0] to_4k;
  logic [16:0] lim;

  // Only the offset inside the current 4 KB page matters for the boundary.
  assign word_off = addr_off >> SIZE_LOG;
  assign to_4k    = 17'(WORDS_4K) - {5'd0, word_off};

  always_comb begin
    lim = 17'(MAX_BURST);
    if (to_4k < lim) lim = to_4k;
    if ({1'b0, remaining} < lim) lim = {1'b0, remaining};
    beats = lim[8:0];
  end

endmodule

// File: rtl/axi_ram_filler.sv
// AXI4 write master that fills a RAM region with seed, seed+1, ... in 4 KB-safe INCR bursts.
// Latency: AW one cycle after start; done one cycle after the final B (or after start when n=0).
// Backpressure: AW, W and B each wait on their handshake; one burst outstanding, AW and W never overlap.
// Ports: start/base_addr/num_words/pattern_seed - request (sampled in IDLE only)
//        busy/done/error                        - status (error sticky until next accepted start)
//        m_axi_aw*/m_axi_w*/m_axi_b*            - AXI4 write channels (no read channels)
module axi_ram_filler
  import axi_pkg::*;
#(
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int MAX_BURST          = 16
) (
  input  logic                              m_axi_aclk,
  input  logic                              m_axi_aresetn,
  input  logic                              start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     base_addr,
  input  logic [15:0]                       num_words,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     pattern_seed,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  output logic [C_M_AXI_ID_WIDTH-1:0]       m_axi_awid,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                        m_axi_awlen,
  output logic [2:0]                        m_axi_awsize,
  output logic [1:0]                        m_axi_awburst,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                              m_axi_wlast,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  input  logic [1:0]                        m_axi_bresp,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready
);

  localparam int unsigned SIZE_LOG = 32'(axi_size_from_width(C_M_AXI_DATA_WIDTH));
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ALIGN_MASK =
    C_M_AXI_ADDR_WIDTH'((32'd1 << SIZE_LOG) - 32'd1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_DONE} state_t;

  state_t state_q, state_d;

  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;       // start address of current/next burst
  logic [15:0]                   remaining_q;  // beats not yet covered by a completed burst
  logic [C_M_AXI_DATA_WIDTH-1:0] word_q;       // pattern word for the current beat
  logic [8:0]                    burst_q;      // beats in the burst in flight
  logic [8:0]                    beat_cnt_q;   // beats left in the burst in flight
  logic                          error_q;
  logic [8:0]                    calc_beats;
  logic                          last_beat;

  // addr_q and remaining_q only move at the end of a burst, so awlen is stable in ADDR.
  axi_burst_calc #(
    .DATA_W    (C_M_AXI_DATA_WIDTH),
    .MAX_BURST (MAX_BURST)
  ) u_burst_calc (
    .addr_off  (addr_q[11:0]),
    .remaining (remaining_q),
    .beats     (calc_beats)
  );

  assign last_beat = (beat_cnt_q == 9'd1);

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) state_q <= S_IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    busy          = 1'b0;
    done          = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_awlen   = 8'd0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (num_words == 16'd0) ? S_DONE : S_ADDR;
      end
      S_ADDR: begin
        busy          = 1'b1;
        m_axi_awvalid = 1'b1;
        m_axi_awlen   = 8'(calc_beats - 9'd1);
        if (m_axi_awready) state_d = S_DATA;
      end
      S_DATA: begin
        busy         = 1'b1;
        m_axi_wvalid = 1'b1;
        m_axi_wlast  = last_beat;
        if (m_axi_wready && last_beat) state_d = S_RESP;
      end
      S_RESP: begin
        busy         = 1'b1;
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          // A bad response aborts the whole request rather than just the burst.
          if (m_axi_bresp != AXI_RESP_OKAY || remaining_q == 16'd0) state_d = S_DONE;
          else                                                      state_d = S_ADDR;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      addr_q      <= '0;
      remaining_q <= '0;
      word_q      <= '0;
      burst_q     <= '0;
      beat_cnt_q  <= '0;
      error_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q      <= base_addr & ~ALIGN_MASK;
            remaining_q <= num_words;
            word_q      <= pattern_seed;
            error_q     <= 1'b0;
          end
        end
        S_ADDR: begin
          if (m_axi_awready) begin
            burst_q    <= calc_beats;
            beat_cnt_q <= calc_beats;
          end
        end
        S_DATA: begin
          if (m_axi_wready) begin
            word_q     <= word_q + C_M_AXI_DATA_WIDTH'(1);
            beat_cnt_q <= beat_cnt_q - 9'd1;
            if (last_beat) begin
              addr_q      <= addr_q + (C_M_AXI_ADDR_WIDTH'(burst_q) << SIZE_LOG);
              remaining_q <= remaining_q - 16'(burst_q);
            end
          end
        end
        S_RESP: begin
          if (m_axi_bvalid && m_axi_bresp != AXI_RESP_OKAY) error_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign error         = error_q;
  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awsize  = axi_size_from_width(C_M_AXI_DATA_WIDTH);
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_wdata   = word_q;
  assign m_axi_wstrb   = '1;

endmodule
